instr_fetch_unit: RTL and testbench

//   Consumer end of the program-counter interface: reads pc_reg, fetches the instruction word
//   at that address from instruction memory over a req/gnt + rvalid bus, and advances the PC.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit boundary: program-counter handshake, instruction-memory bus and decode port.
// The fetch unit connects through "master"; the surrounding pipeline and memory connect through "slave".
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_reg;
  logic              pc_adv;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              flush;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    input  pc_reg, imem_gnt, imem_rvalid, imem_rdata, flush, inst_ready,
    output pc_adv, imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output pc_reg, imem_gnt, imem_rvalid, imem_rdata, flush, inst_ready,
    input  pc_adv, imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one outstanding read per PC over req/gnt + rvalid, advances
// the PC on grant and buffers {pc, word} pairs in a small FIFO towards decode.
module instr_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] req_pc;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic req, grant, push, pop, has_space;

  // Space is checked at issue; with a single outstanding request the later push always fits.
  assign has_space = (count < CNT_W'(FIFO_DEPTH));
  assign pop       = bus.inst_valid & bus.inst_ready;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    grant     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        req = has_space & ~reset;
        if (req && bus.imem_gnt) begin
          grant     = 1'b1;
          state_nxt = bus.flush ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push      = ~bus.flush;
          state_nxt = REQ;
        end else if (bus.flush) begin
          state_nxt = DROP;
        end
      end
      DROP: if (bus.imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (grant) req_pc <= bus.pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only visible while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = bus.pc_reg;
  assign bus.pc_adv     = grant;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = bus.inst_valid ? fifo_data[rd_ptr] : '0;
  assign bus.inst_pc    = bus.inst_valid ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a PC owner, a variable-latency memory and a decode
// sink drive the unit, and a queue-based model of the expected instruction stream checks it.
module tb_instr_fetch_unit;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int delivered = 0;

  // Reference model: what decode should see, and the single request in flight.
  entry_t            exp_q[$];
  bit                idle;
  bit                outstanding;
  bit                doomed;
  logic [ADDR_W-1:0] out_addr;

  // Environment: PC owner and memory responder.
  logic [ADDR_W-1:0] pc_next;
  bit                pending;
  int                wait_left;
  logic [ADDR_W-1:0] resp_addr;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_phase(input int cycles, input int gnt_pct, input int max_dly,
                           input int ready_pct, input int flush_pct, input int reset_pct);
    logic              req_exp;
    logic [ADDR_W-1:0] redirect;
    bit                fired;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      // Drive this cycle's inputs.
      reset           = ($urandom_range(99, 0) < reset_pct);
      bus.pc_reg      = pc_next;
      bus.imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
      bus.inst_ready  = ($urandom_range(99, 0) < ready_pct);
      bus.flush       = ($urandom_range(99, 0) < flush_pct);
      bus.imem_rvalid = pending && (wait_left == 0);
      bus.imem_rdata  = bus.imem_rvalid ? mem_word(resp_addr) : DATA_W'($urandom);
      redirect        = ADDR_W'($urandom & 32'h0000_0FFC);
      #1;
      // Compare against the model.
      req_exp = !reset && !idle && !outstanding && (exp_q.size() < FIFO_DEPTH);
      check("imem_req", 64'(bus.imem_req), 64'(req_exp));
      check("pc_adv", 64'(bus.pc_adv), 64'(req_exp && bus.imem_gnt));
      if (req_exp) check("imem_addr", 64'(bus.imem_addr), 64'(bus.pc_reg));
      check("inst_valid", 64'(bus.inst_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("inst_pc", 64'(bus.inst_pc), 64'(exp_q[0].pc));
        check("inst_data", 64'(bus.inst_data), 64'(exp_q[0].data));
      end
      if (idle) begin
        check("reset_inst_pc", 64'(bus.inst_pc), 64'd0);
        check("reset_inst_data", 64'(bus.inst_data), 64'd0);
      end
      // Advance environment and model to the upcoming edge.
      fired = bus.imem_rvalid;
      if (reset) begin
        exp_q.delete();
        idle        = 1'b1;
        outstanding = 1'b0;
        doomed      = 1'b0;
        pending     = 1'b0;
        pc_next     = '0;
      end else begin
        idle = 1'b0;
        if (bus.flush) exp_q.delete();
        else if (exp_q.size() != 0 && bus.inst_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (fired && outstanding) begin
          if (!bus.flush && !doomed) exp_q.push_back('{pc: out_addr, data: mem_word(out_addr)});
          outstanding = 1'b0;
        end
        if (req_exp && bus.imem_gnt) begin
          outstanding = 1'b1;
          out_addr    = bus.pc_reg;
          doomed      = bus.flush;
        end else if (bus.flush && outstanding) begin
          doomed = 1'b1;
        end
        if (fired) pending = 1'b0;
        if (bus.imem_req && bus.imem_gnt) begin
          pending   = 1'b1;
          resp_addr = bus.imem_addr;
          wait_left = $urandom_range(max_dly - 1, 0);
        end else if (pending && !fired) begin
          wait_left--;
        end
        if (bus.flush)       pc_next = redirect;
        else if (bus.pc_adv) pc_next = bus.pc_reg + ADDR_W'(4);
      end
    end
  endtask

  initial begin
    bus.pc_reg      = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.flush       = 1'b0;
    bus.inst_ready  = 1'b0;
    idle        = 1'b1;
    outstanding = 1'b0;
    doomed      = 1'b0;
    pending     = 1'b0;
    wait_left   = 0;
    pc_next     = '0;
    out_addr    = '0;
    resp_addr   = '0;

    // Reset held, then back-to-back fetches with single-cycle memory.
    run_phase(3, 100, 1, 100, 0, 100);
    run_phase(40, 100, 1, 100, 0, 0);
    // Decode stalled: buffer fills and requests stop, then drains in order.
    run_phase(20, 100, 1, 0, 0, 0);
    check("full_req_low", 64'(bus.imem_req), 64'd0);
    run_phase(20, 100, 1, 100, 0, 0);
    // Slow grant and slow response.
    run_phase(80, 25, 5, 100, 0, 0);
    // Flushes landing in every fetch phase, including rvalid and pop cycles.
    run_phase(400, 60, 3, 70, 15, 0);
    // Everything random, including mid-fetch resets.
    run_phase(600, 50, 4, 60, 8, 3);
    run_phase(30, 100, 1, 100, 0, 0);
    check("progress", 64'(delivered > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
